// File: rtl/ifft8_pkg.sv
// ifft8_pkg: shared sizes, Q14 twiddle tables, bit-reversal helper and the
// controller/butterfly phase enums for the 8-point inverse FFT.
package ifft8_pkg;

  localparam int N     = 8;
  localparam int LOG2N = 3;
  localparam int DW    = 32;   // real / imag part width
  localparam int QW    = 14;   // twiddle fraction bits
  localparam int CW    = 16;   // twiddle word width
  localparam int PW    = 48;   // product width

  // Conjugated twiddles W^-k = cos + j*sin, k = 0..3, Q14
  localparam logic signed [CW-1:0] TW_COS [4] = '{16'sd16384, 16'sd11584, 16'sd0, -16'sd11584};
  localparam logic signed [CW-1:0] TW_SIN [4] = '{16'sd0, 16'sd11584, 16'sd16384, 16'sd11584};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  typedef enum logic [1:0] {ISSUE, MUL, WB} phase_e;

  function automatic logic [2:0] bitrev3(input logic [2:0] i);
    return {i[0], i[1], i[2]};
  endfunction

endpackage

// File: rtl/ifft8_if.sv
// ifft8_if: start/busy/done handshake plus the eight input bins and eight
// output samples. Each 64-bit word is {imag[63:32], real[31:0]}.
interface ifft8_if;

  logic                          start;
  logic [2*ifft8_pkg::DW-1:0]    din0, din1, din2, din3, din4, din5, din6, din7;
  logic                          busy;
  logic                          done;
  logic [2*ifft8_pkg::DW-1:0]    dout0, dout1, dout2, dout3, dout4, dout5, dout6, dout7;

  modport master (
    output start,
    output din0, din1, din2, din3, din4, din5, din6, din7,
    input  busy, done,
    input  dout0, dout1, dout2, dout3, dout4, dout5, dout6, dout7
  );

  modport slave (
    input  start,
    input  din0, din1, din2, din3, din4, din5, din6, din7,
    output busy, done,
    output dout0, dout1, dout2, dout3, dout4, dout5, dout6, dout7
  );

endinterface

// File: rtl/ifft8_btf.sv
// ifft8_btf: shared radix-2 butterfly. Products of b with the twiddle are
// registered when mul_en is high; a' = a + t and b' = a - t are then formed
// combinationally from the registered products.
// Build option: IFFT8_SCALE_EN halves a' and b' (arithmetic shift) so three
// stages give the true 1/8-scaled IFFT; otherwise results just wrap to 32 bits.
module ifft8_btf
  import ifft8_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mul_en,
  input  logic signed [DW-1:0] a_re,
  input  logic signed [DW-1:0] a_im,
  input  logic signed [DW-1:0] b_re,
  input  logic signed [DW-1:0] b_im,
  input  logic signed [CW-1:0] tw_cos,
  input  logic signed [CW-1:0] tw_sin,
  output logic signed [DW-1:0] ap_re,
  output logic signed [DW-1:0] ap_im,
  output logic signed [DW-1:0] bp_re,
  output logic signed [DW-1:0] bp_im
);

  logic signed [PW-1:0] p_rc_d, p_is_d, p_rs_d, p_ic_d;
  logic signed [PW-1:0] p_rc_q, p_is_q, p_rs_q, p_ic_q;
  logic signed [DW-1:0] a_re_d, a_im_d, a_re_q, a_im_q;
  logic signed [DW-1:0] t_re, t_im;
  logic signed [DW:0]   sum_re, sum_im, dif_re, dif_im;

  // Capture the four partial products and operand a; hold otherwise
  always_comb begin
    p_rc_d = p_rc_q;
    p_is_d = p_is_q;
    p_rs_d = p_rs_q;
    p_ic_d = p_ic_q;
    a_re_d = a_re_q;
    a_im_d = a_im_q;
    if (mul_en) begin
      p_rc_d = PW'(b_re) * PW'(tw_cos);
      p_is_d = PW'(b_im) * PW'(tw_sin);
      p_rs_d = PW'(b_re) * PW'(tw_sin);
      p_ic_d = PW'(b_im) * PW'(tw_cos);
      a_re_d = a_re;
      a_im_d = a_im;
    end
  end

  // Product pipeline register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_rc_q <= '0;
      p_is_q <= '0;
      p_rs_q <= '0;
      p_ic_q <= '0;
      a_re_q <= '0;
      a_im_q <= '0;
    end else begin
      p_rc_q <= p_rc_d;
      p_is_q <= p_is_d;
      p_rs_q <= p_rs_d;
      p_ic_q <= p_ic_d;
      a_re_q <= a_re_d;
      a_im_q <= a_im_d;
    end
  end

  // Rotated b floored back to integer, then 33-bit add/sub and scaling
  always_comb begin
    t_re   = DW'((p_rc_q - p_is_q) >>> QW);
    t_im   = DW'((p_rs_q + p_ic_q) >>> QW);
    sum_re = (DW+1)'(a_re_q) + (DW+1)'(t_re);
    sum_im = (DW+1)'(a_im_q) + (DW+1)'(t_im);
    dif_re = (DW+1)'(a_re_q) - (DW+1)'(t_re);
    dif_im = (DW+1)'(a_im_q) - (DW+1)'(t_im);
`ifdef IFFT8_SCALE_EN
    ap_re = DW'(sum_re >>> 1);
    ap_im = DW'(sum_im >>> 1);
    bp_re = DW'(dif_re >>> 1);
    bp_im = DW'(dif_im >>> 1);
`else
    ap_re = DW'(sum_re);
    ap_im = DW'(sum_im);
    bp_re = DW'(dif_re);
    bp_im = DW'(dif_im);
`endif
  end

endmodule

// File: rtl/ifft8_core.sv
// ifft8_core: iterative 8-point radix-2 DIT inverse FFT. Input bins are
// loaded in bit-reversed order, then one shared butterfly runs 3 stages x 4
// pairs, 3 cycles each (ISSUE / MUL / WB). Outputs are registered on DONE.
// Scaling follows the IFFT8_SCALE_EN build option inside ifft8_btf.
module ifft8_core
  import ifft8_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  ifft8_if.slave bus
);

  typedef logic [2*DW-1:0] word_t;

  state_e               state_q, state_d;
  phase_e               phase_q, phase_d;
  logic [1:0]           stage_q, stage_d;
  logic [1:0]           group_q, group_d;
  logic [1:0]           step_q, step_d;
  word_t                mem_q [N];
  word_t                mem_d [N];
  word_t                op_a_q, op_a_d, op_b_q, op_b_d;
  logic signed [CW-1:0] cos_q, cos_d, sin_q, sin_d;
  logic                 busy_q, busy_d, done_q, done_d;
  word_t                dout_q [N];
  word_t                dout_d [N];

  word_t                din_w [N];
  logic [LOG2N-1:0]     idx_a, idx_b;
  logic [1:0]           tw_idx;
  logic                 last_step, last_group, mul_en;
  logic signed [DW-1:0] ap_re, ap_im, bp_re, bp_im;

  assign din_w[0] = bus.din0;
  assign din_w[1] = bus.din1;
  assign din_w[2] = bus.din2;
  assign din_w[3] = bus.din3;
  assign din_w[4] = bus.din4;
  assign din_w[5] = bus.din5;
  assign din_w[6] = bus.din6;
  assign din_w[7] = bus.din7;

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.dout0 = dout_q[0];
  assign bus.dout1 = dout_q[1];
  assign bus.dout2 = dout_q[2];
  assign bus.dout3 = dout_q[3];
  assign bus.dout4 = dout_q[4];
  assign bus.dout5 = dout_q[5];
  assign bus.dout6 = dout_q[6];
  assign bus.dout7 = dout_q[7];

  assign mul_en = (state_q == RUN) && (phase_q == MUL);

  ifft8_btf u_btf (
    .clk    (clk),
    .rst    (rst),
    .mul_en (mul_en),
    .a_re   (op_a_q[DW-1:0]),
    .a_im   (op_a_q[2*DW-1:DW]),
    .b_re   (op_b_q[DW-1:0]),
    .b_im   (op_b_q[2*DW-1:DW]),
    .tw_cos (cos_q),
    .tw_sin (sin_q),
    .ap_re  (ap_re),
    .ap_im  (ap_im),
    .bp_re  (bp_re),
    .bp_im  (bp_im)
  );

  // Pair addresses, twiddle index and loop-end flags from stage/group/step
  always_comb begin
    idx_a      = '0;
    idx_b      = '0;
    tw_idx     = '0;
    last_step  = 1'b1;
    last_group = 1'b0;
    case (stage_q)
      2'd0: begin
        idx_a      = {group_q, 1'b0};
        idx_b      = {group_q, 1'b1};
        tw_idx     = 2'd0;
        last_step  = 1'b1;
        last_group = (group_q == 2'd3);
      end
      2'd1: begin
        idx_a      = {group_q[0], 1'b0, step_q[0]};
        idx_b      = {group_q[0], 1'b1, step_q[0]};
        tw_idx     = {step_q[0], 1'b0};
        last_step  = step_q[0];
        last_group = group_q[0];
      end
      default: begin
        idx_a      = {1'b0, step_q};
        idx_b      = {1'b1, step_q};
        tw_idx     = step_q;
        last_step  = (step_q == 2'd3);
        last_group = 1'b1;
      end
    endcase
  end

  // Controller next state: load, butterfly sequencing, output capture
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    stage_d = stage_q;
    group_d = group_q;
    step_d  = step_q;
    mem_d   = mem_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    cos_d   = cos_q;
    sin_d   = sin_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dout_d  = dout_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          for (int i = 0; i < N; i++) begin
            mem_d[bitrev3(3'(i))] = din_w[i];
          end
          stage_d = '0;
          group_d = '0;
          step_d  = '0;
          phase_d = ISSUE;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        case (phase_q)
          ISSUE: begin
            op_a_d  = mem_q[idx_a];
            op_b_d  = mem_q[idx_b];
            cos_d   = TW_COS[tw_idx];
            sin_d   = TW_SIN[tw_idx];
            phase_d = MUL;
          end
          MUL: begin
            phase_d = WB;
          end
          default: begin
            // counters are untouched since ISSUE, so idx_a/idx_b still name this pair
            mem_d[idx_a] = {ap_im, ap_re};
            mem_d[idx_b] = {bp_im, bp_re};
            phase_d      = ISSUE;
            if (last_step) begin
              step_d = '0;
              if (last_group) begin
                group_d = '0;
                if (stage_q == 2'd2) begin
                  state_d = DONE;
                end else begin
                  stage_d = stage_q + 2'd1;
                end
              end else begin
                group_d = group_q + 2'd1;
              end
            end else begin
              step_d = step_q + 2'd1;
            end
          end
        endcase
      end
      DONE: begin
        dout_d  = mem_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Controller, working memory and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= ISSUE;
      stage_q <= '0;
      group_q <= '0;
      step_q  <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      cos_q   <= '0;
      sin_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < N; i++) begin
        mem_q[i]  <= '0;
        dout_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      stage_q <= stage_d;
      group_q <= group_d;
      step_q  <= step_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      cos_q   <= cos_d;
      sin_q   <= sin_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mem_q   <= mem_d;
      dout_q  <= dout_d;
    end
  end

endmodule

// File: doc/ifft8_core.md
# ifft8_core

Iterative 8-point radix-2 decimation-in-time inverse FFT for 64-bit complex words, with 32-bit signed real and imaginary parts. It is the return path to the team's forward `fft8`: it takes spectra in natural bin order and produces time samples in natural order. It uses the same word packing and the same Q14 twiddle magnitudes, with conjugated twiddles (positive sine). A single shared butterfly is time-multiplexed over 3 stages × 4 butterflies.

## Interface
- No parameters. Sizes are fixed by package constants.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `din0`..`din7` in 64 each: bins X[0..7]; [63:32] = imag, [31:0] = real, both two's complement.
- `busy` out 1: high from the cycle after `start` is accepted until `done`.
- `done` out 1: one-cycle pulse when `dout*` are updated.
- `dout0`..`dout7` out 64 each: time samples x[0..7], same packing; held until the next `done`.

## Operation
- FSM states: IDLE → RUN → DONE → IDLE.
- IDLE, `start`=1: load `mem[bitrev3(i)] <= din_i`; clear stage, group and step counters; go to RUN.
- RUN: stage s = 0..2, span = 1<<s. Pairs (k, k+span) in ascending k within each group.
  - Twiddle index = (k mod span) × (4>>s).
  - Each butterfly takes 3 cycles: ISSUE (read operands and twiddle), MUL (registered products), WB (write both results back to `mem`).
- After the last WB: DONE copies `mem[i]` to `dout_i`, pulses `done`, returns to IDLE.
- Twiddle W = cos + j·sin, Q14:
  - cos = {16384, 11584, 0, −11584}
  - sin = {0, 11584, 16384, 11584}
- Butterfly on inputs a, b:
  - tr = (br·c − bi·s) >>> 14; ti = (br·s + bi·c) >>> 14.
  - Products are 48-bit signed; the shift is arithmetic (floor) and the result is truncated to 32 bits.
  - a' = a + t; b' = a − t, each computed 33-bit and then scaled per Configuration.
- `start` while busy or in DONE: ignored, with no queueing.
- Overflow: two's-complement wrap in 32 bits; no saturation.
- Reset at any point:
  - FSM to IDLE; `mem`, counters and pipeline registers cleared.
  - `busy`=0, `done`=0, all `dout*`=0.
  - A `start` on the first cycle after reset deassertion is accepted normally.

## Timing
- Reset values: `busy`=0, `done`=0, `dout0..7`=64'd0.
- `start` sampled high at edge E0 (load).
- `busy`=1 after E0. Butterflies occupy edges E1..E36 (12 × 3).
- E37: `dout*` registered, `done`=1 for one cycle, `busy`=0.
- `start` at E38 (first IDLE cycle after `done`) is accepted, giving back-to-back throughput of 38 cycles per transform.
- WB of butterfly n always completes before ISSUE of butterfly n+1; there is no read-after-write hazard.

## Configuration
- `IFFT8_SCALE_EN` defined: a' and b' are shifted arithmetic right by 1 before truncation to 32 bits, giving a total scale of 1/8 (true IFFT).
- Not defined: no per-stage shift; a' and b' are truncated to 32 bits. The output is 8× the IFFT, and overflow wraps.

## Structure
- Package `ifft8_pkg` holds:
  - `N`=8, `LOG2N`=3, `DW`=32, `QW`=14.
  - Twiddle cos/sin constant arrays.
  - The `bitrev3` function.
  - The FSM state enum {IDLE, RUN, DONE}.
  - The butterfly phase enum {ISSUE, MUL, WB}.
- Sub-module `ifft8_btf`: the complex multiply and add/sub with registered products.
  - Inputs a, b, cos, sin; outputs a', b'.
  - Scaling is controlled by `IFFT8_SCALE_EN`.
- The top level owns the FSM, counters, `mem` and the output registers.

## Test plan
- Impulse: `din0`=re 8000, all others 0, scale on → every `dout*` = re 1000, im 0; `done` 37 cycles after `start`.
- Single bin: `din1`=re 8192, scale on →
  - `dout0`=1024; `dout2`=+1024j; `dout4`=−1024; `dout6`=−1024j.
  - Odd outputs have magnitude 724±1 per part, with quadrant signs (+,+), (−,+), (−,−), (+,−).
- Round trip: 8 random bounded vectors (|part| < 2^20) through `fft8`, then `ifft8_core` with scale on, matches the original within ±8 LSB.
- `start` held high for 40 cycles →
  - exactly one transform completes, with `done` at E37;
  - the second `start` is accepted at E38;
  - `busy` never drops mid-run.
- Reset asserted at E20 → `busy`, `done`, `dout*` are 0 immediately; a new impulse run afterwards gives the correct result.
- Scale off: impulse re 8000 → every `dout*` = re 8000.
